pipelined_control_unit: RTL and testbench

Pipelined decoder for the reduced RV32I core. It decodes the instruction in the Decode stage, holds the resulting control word in a Decode/Execute pipeline register, and detects load-use hazards, which it signals as a stall. It also inserts bubbles on stall and branch flush, resolves branches in Execute, and flags unsupported opcodes. It sits between the F/D instruction register and the datapath/ALU.

---
 rtl/pipelined_control_unit_if.sv | 35 +++
 rtl/pipelined_control_unit.sv | 161 ++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pipelined_control_unit_if.sv
// Decode/Execute control bus between the F/D register, the control unit
// and the datapath. The slave side is the control unit itself.
interface pipelined_control_unit_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 3
);
    logic [DATA_WIDTH-1:0]     instr_i;
    logic                      instr_valid_i;
    logic                      EQ;
    logic [1:0]                ImmSrcD;
    logic                      stall_o;
    logic                      RegWriteE;
    logic                      ALUsrcE;
    logic                      MEMWriteE;
    logic                      MEMsrcE;
    logic [ALU_CTRL_WIDTH-1:0] ALUctrlE;
    logic [REG_ADDR_WIDTH-1:0] rdE;
    logic                      validE;
    logic                      PCsrcE;
    logic                      flush_o;
    logic                      illegal_o;

    modport master (
        output instr_i, instr_valid_i, EQ,
        input  ImmSrcD, stall_o, RegWriteE, ALUsrcE, MEMWriteE, MEMsrcE,
               ALUctrlE, rdE, validE, PCsrcE, flush_o, illegal_o
    );

    modport slave (
        input  instr_i, instr_valid_i, EQ,
        output ImmSrcD, stall_o, RegWriteE, ALUsrcE, MEMWriteE, MEMsrcE,
               ALUctrlE, rdE, validE, PCsrcE, flush_o, illegal_o
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Reduced RV32I decoder with a Decode/Execute control register, load-use
// stall detection, bubble insertion on stall/flush, Execute-stage branch
// resolution and a sticky illegal-instruction flag.
module pipelined_control_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pipelined_control_unit_if.slave   bus
);
    typedef struct packed {
        logic                      reg_write;
        logic                      alu_src;
        logic                      mem_write;
        logic                      mem_src;
        logic                      branch;
        logic                      branch_ne;
        logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {ALU_CTRL_WIDTH{1'b1}}};

    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic                      f7b5;
    logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
    logic                      unused_instr;

    assign opcode       = bus.instr_i[6:0];
    assign funct3       = bus.instr_i[14:12];
    assign f7b5         = bus.instr_i[30];
    assign rd           = REG_ADDR_WIDTH'(bus.instr_i[11:7]);
    assign rs1          = REG_ADDR_WIDTH'(bus.instr_i[19:15]);
    assign rs2          = REG_ADDR_WIDTH'(bus.instr_i[24:20]);
    assign unused_instr = ^{bus.instr_i[DATA_WIDTH-1:31], bus.instr_i[29:25]};

    ctrl_t                     dec_ctrl;
    logic                      legal, rs1_used, rs2_used, dec_valid;
    logic [1:0]                imm_src;

    ctrl_t                     ctrl_q, ctrl_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      valid_q, valid_d;
    logic                      illegal_q, illegal_d;
    logic                      stall, pcsrc;

    // Decode the Decode-stage instruction into a control word; anything not
    // recognised (or not valid) collapses to a bubble.
    always_comb begin
        dec_ctrl = '0;
        legal    = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        imm_src  = 2'b00;
        case (opcode)
            7'b0110011: begin
                legal              = 1'b1;
                rs1_used           = 1'b1;
                rs2_used           = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                case (funct3)
                    3'b000:  dec_ctrl.alu_ctrl = f7b5 ? ALU_CTRL_WIDTH'(1) : ALU_CTRL_WIDTH'(0);
                    3'b111:  dec_ctrl.alu_ctrl = ALU_CTRL_WIDTH'(2);
                    3'b110:  dec_ctrl.alu_ctrl = ALU_CTRL_WIDTH'(3);
                    3'b010:  dec_ctrl.alu_ctrl = ALU_CTRL_WIDTH'(5);
                    default: legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                legal              = 1'b1;
                rs1_used           = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                case (funct3)
                    3'b000:  dec_ctrl.alu_ctrl = ALU_CTRL_WIDTH'(0);
                    3'b111:  dec_ctrl.alu_ctrl = ALU_CTRL_WIDTH'(2);
                    3'b110:  dec_ctrl.alu_ctrl = ALU_CTRL_WIDTH'(3);
                    3'b010:  dec_ctrl.alu_ctrl = ALU_CTRL_WIDTH'(5);
                    default: legal = 1'b0;
                endcase
            end
            7'b0000011: begin
                legal              = (funct3 == 3'b010);
                rs1_used           = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_src   = 1'b1;
            end
            7'b0100011: begin
                legal              = (funct3 == 3'b010);
                rs1_used           = 1'b1;
                rs2_used           = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                imm_src            = 2'b01;
            end
            7'b1100011: begin
                legal              = (funct3 == 3'b000) || (funct3 == 3'b001);
                rs1_used           = 1'b1;
                rs2_used           = 1'b1;
                dec_ctrl.branch    = (funct3 == 3'b000);
                dec_ctrl.branch_ne = (funct3 == 3'b001);
                dec_ctrl.alu_ctrl  = ALU_CTRL_WIDTH'(1);
                imm_src            = 2'b10;
            end
            default: legal = 1'b0;
        endcase
        dec_valid = legal & bus.instr_valid_i;
        if (!dec_valid) begin
            dec_ctrl = BUBBLE;
            rs1_used = 1'b0;
            rs2_used = 1'b0;
        end
    end

    // Hazard/branch resolution and D/E next state: flush beats stall beats decode.
    always_comb begin
        stall = valid_q & ctrl_q.mem_src & (rd_q != '0) & dec_valid &
                ((rs1_used & (rs1 == rd_q)) | (rs2_used & (rs2 == rd_q)));
        pcsrc = valid_q & ((ctrl_q.branch & bus.EQ) | (ctrl_q.branch_ne & ~bus.EQ));
        ctrl_d    = dec_ctrl;
        rd_d      = dec_valid ? rd : '0;
        valid_d   = dec_valid;
        illegal_d = illegal_q | (~pcsrc & bus.instr_valid_i & ~legal);
        if (pcsrc || stall) begin
            ctrl_d  = BUBBLE;
            rd_d    = '0;
            valid_d = 1'b0;
        end
    end

    // D/E pipeline register and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= BUBBLE;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.ImmSrcD   = imm_src;
    assign bus.stall_o   = stall;
    assign bus.RegWriteE = ctrl_q.reg_write;
    assign bus.ALUsrcE   = ctrl_q.alu_src;
    assign bus.MEMWriteE = ctrl_q.mem_write;
    assign bus.MEMsrcE   = ctrl_q.mem_src;
    assign bus.ALUctrlE  = ctrl_q.alu_ctrl;
    assign bus.rdE       = rd_q;
    assign bus.validE    = valid_q;
    assign bus.PCsrcE    = pcsrc;
    assign bus.flush_o   = pcsrc;
    assign bus.illegal_o = illegal_q;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: reset, decode, load-use
// stalls, branch flush, flush-vs-stall and the sticky illegal flag.
module tb_pipelined_control_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    localparam logic [31:0] ADDI    = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] LW_X5   = 32'h0000_2283; // lw x5,0(x0)
    localparam logic [31:0] LW_X0   = 32'h0000_2003; // lw x0,0(x0)
    localparam logic [31:0] ADD_DEP = 32'h0012_8333; // add x6,x5,x1
    localparam logic [31:0] ADD_X0  = 32'h0010_0333; // add x6,x0,x1
    localparam logic [31:0] SW_X7   = 32'h0071_2023; // sw x7,0(x2)
    localparam logic [31:0] SW_X5   = 32'h0051_2023; // sw x5,0(x2)
    localparam logic [31:0] BEQ     = 32'h0000_0063; // beq x0,x0,0
    localparam logic [31:0] BNE     = 32'h0000_1063; // bne x0,x0,0
    localparam logic [31:0] ECALL   = 32'h0000_0073;

    pipelined_control_unit_if u_if ();

    pipelined_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        u_if.instr_i       = ADDI;
        u_if.instr_valid_i = 1'b1;
        u_if.EQ            = 1'b0;

        // Reset state
        #12;
        chk("rst_validE",   u_if.validE, 0);
        chk("rst_ALUctrlE", u_if.ALUctrlE, 3'b111);
        chk("rst_RegWrite", u_if.RegWriteE, 0);
        chk("rst_stall",    u_if.stall_o, 0);
        chk("rst_illegal",  u_if.illegal_o, 0);
        chk("rst_flush",    u_if.flush_o, 0);
        rst_n = 1'b1;

        // addi reaches Execute one cycle later
        tick();
        chk("addi_RegWrite", u_if.RegWriteE, 1);
        chk("addi_ALUsrc",   u_if.ALUsrcE, 1);
        chk("addi_ALUctrl",  u_if.ALUctrlE, 3'b000);
        chk("addi_rdE",      u_if.rdE, 1);
        chk("addi_validE",   u_if.validE, 1);

        // Load-use on rs1: one-cycle stall, bubble, then add
        u_if.instr_i = LW_X5;
        tick();
        chk("lw_MEMsrc", u_if.MEMsrcE, 1);
        u_if.instr_i = ADD_DEP;
        #1;
        chk("lu_stall", u_if.stall_o, 1);
        tick();
        chk("lu_bubble_validE", u_if.validE, 0);
        chk("lu_stall_gone",    u_if.stall_o, 0);
        tick();
        chk("lu_add_validE",  u_if.validE, 1);
        chk("lu_add_ALUctrl", u_if.ALUctrlE, 3'b000);
        chk("lu_add_rdE",     u_if.rdE, 6);

        // Load to x0 never stalls
        u_if.instr_i = LW_X0;
        tick();
        u_if.instr_i = ADD_X0;
        #1;
        chk("x0_no_stall", u_if.stall_o, 0);

        // sw with non-matching rs2 does not stall
        u_if.instr_i = LW_X5;
        tick();
        u_if.instr_i = SW_X7;
        #1;
        chk("sw_x7_no_stall", u_if.stall_o, 0);
        chk("sw_ImmSrc",      u_if.ImmSrcD, 2'b01);
        tick();

        // sw with matching rs2 stalls one cycle
        u_if.instr_i = LW_X5;
        tick();
        u_if.instr_i = SW_X5;
        #1;
        chk("sw_x5_stall", u_if.stall_o, 1);
        tick();
        chk("sw_x5_bubble", u_if.validE, 0);
        tick();
        chk("sw_MEMWrite", u_if.MEMWriteE, 1);
        chk("sw_RegWrite", u_if.RegWriteE, 0);

        // beq taken: flush and bubble
        u_if.instr_i = BEQ;
        #1;
        chk("beq_ImmSrc", u_if.ImmSrcD, 2'b10);
        tick();
        u_if.instr_i = ADDI;
        u_if.EQ      = 1'b1;
        #1;
        chk("beq_PCsrc", u_if.PCsrcE, 1);
        chk("beq_flush", u_if.flush_o, 1);
        tick();
        chk("beq_bubble", u_if.validE, 0);
        chk("beq_no_repeat", u_if.PCsrcE, 0);
        u_if.EQ = 1'b0;

        // bne with EQ=1 not taken
        u_if.instr_i = BNE;
        tick();
        u_if.instr_i = ADDI;
        u_if.EQ      = 1'b1;
        #1;
        chk("bne_eq_PCsrc", u_if.PCsrcE, 0);
        tick();
        chk("bne_next_valid", u_if.validE, 1);
        u_if.EQ = 1'b0;

        // Flush with lw in M and dependent add in Decode
        u_if.instr_i = LW_X5;
        tick();
        u_if.instr_i = BEQ;
        tick();
        u_if.instr_i = ADD_DEP;
        u_if.EQ      = 1'b1;
        #1;
        chk("fl_flush", u_if.flush_o, 1);
        tick();
        chk("fl_bubble",  u_if.validE, 0);
        chk("fl_illegal", u_if.illegal_o, 0);
        u_if.EQ = 1'b0;
        #1;
        chk("fl_no_stall", u_if.stall_o, 0);
        tick();
        chk("fl_add_rdE", u_if.rdE, 6);

        // Flushed ecall does not set illegal
        u_if.instr_i = BEQ;
        tick();
        u_if.instr_i = ECALL;
        u_if.EQ      = 1'b1;
        tick();
        chk("fl_ecall_illegal", u_if.illegal_o, 0);
        u_if.EQ = 1'b0;

        // Invalid ecall is just a bubble
        u_if.instr_valid_i = 1'b0;
        tick();
        chk("inv_ecall_illegal", u_if.illegal_o, 0);
        chk("inv_validE",        u_if.validE, 0);

        // Valid ecall: bubble and sticky illegal
        u_if.instr_valid_i = 1'b1;
        tick();
        chk("ecall_validE",  u_if.validE, 0);
        chk("ecall_illegal", u_if.illegal_o, 1);
        u_if.instr_i = ADDI;
        tick();
        chk("ill_sticky", u_if.illegal_o, 1);
        chk("ill_addi_valid", u_if.validE, 1);
        rst_n = 1'b0;
        #1;
        chk("rst2_illegal", u_if.illegal_o, 0);
        chk("rst2_validE",  u_if.validE, 0);
        chk("rst2_ALUctrl", u_if.ALUctrlE, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
